// File: rtl/trace_pkg.sv
// Shared trace types and default sizing for the trace collector slice.
package trace_pkg;
  localparam int NUM_CH_DEF   = 3;
  localparam int ID_WIDTH_DEF = 32;
  localparam int DEPTH_DEF    = 8;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = ch_w(NUM_CH_DEF);

  // Default-width event view; the collector rebuilds the same layout at its own widths.
  typedef struct packed {
    logic [CH_W_DEF-1:0]     channel;
    logic [ID_WIDTH_DEF-1:0] instance_id;
    logic [ID_WIDTH_DEF-1:0] stmt_id;
  } trace_evt_t;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO; head reads as zero while empty so the outputs are clean in reset.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/trace_collector.sv
// Round-robin trace event collector with FIFO, sticky breakpoint halt and event counter.
module trace_collector
  import trace_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 ch_valid,
  output logic [NUM_CH-1:0]                 ch_ready,
  input  logic [NUM_CH-1:0][ID_WIDTH-1:0]   ch_instance_id,
  input  logic [NUM_CH-1:0][ID_WIDTH-1:0]   ch_stmt_id,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ID_WIDTH-1:0]               out_instance_id,
  output logic [ID_WIDTH-1:0]               out_stmt_id,
  output logic [CH_W-1:0]                   out_channel,
  input  logic                              bp_enable,
  input  logic [ID_WIDTH-1:0]               bp_instance_id,
  input  logic [ID_WIDTH-1:0]               bp_stmt_id,
  output logic                              halted,
  input  logic                              resume,
  output logic [31:0]                       event_count
);
  typedef struct packed {
    logic [CH_W-1:0]     channel;
    logic [ID_WIDTH-1:0] instance_id;
    logic [ID_WIDTH-1:0] stmt_id;
  } evt_t;

  localparam int AW = $clog2(DEPTH);

  logic [CH_W-1:0] rr_ptr_q, sel;
  logic            found, grant_en, accept, match;
  logic            halted_q;
  logic [31:0]     event_count_q;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_cnt;
  logic            unused_cnt;
  evt_t            push_evt, head_evt;

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (ch_valid[c]) begin
        sel   = CH_W'(c);
        found = 1'b1;
      end
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (ch_valid[c] && (CH_W'(c) >= rr_ptr_q)) sel = CH_W'(c);
    end
  end

  assign grant_en = rst_n && !fifo_full && !halted_q;
  assign ch_ready = (grant_en && found) ? (NUM_CH'(1) << sel) : '0;
  assign accept   = |ch_ready;
  assign match    = bp_enable && (ch_instance_id[sel] == bp_instance_id)
                                && (ch_stmt_id[sel] == bp_stmt_id);

  assign push_evt = '{channel: sel, instance_id: ch_instance_id[sel], stmt_id: ch_stmt_id[sel]};

  trace_fifo #(.WIDTH($bits(evt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .din_i   (push_evt),
    .pop_i   (out_ready),
    .dout_o  (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );
  assign unused_cnt = ^fifo_cnt;

  assign out_valid       = !fifo_empty;
  assign out_channel     = head_evt.channel;
  assign out_instance_id = head_evt.instance_id;
  assign out_stmt_id     = head_evt.stmt_id;
  assign halted          = halted_q;
  assign event_count     = event_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      halted_q      <= 1'b0;
      event_count_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q      <= (sel == CH_W'(NUM_CH-1)) ? '0 : sel + 1'b1;
        event_count_q <= event_count_q + 32'd1;
      end
      // A hit on this cycle's accept outranks a concurrent resume.
      if (accept && match) halted_q <= 1'b1;
      else if (resume)     halted_q <= 1'b0;
    end
  end
endmodule
